// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one combinational ALU
//
// Purpose: accepts one operation at a time from m0 or m1, drives it to the
// shared ALU for one cycle, captures the result and holds it until the owning
// requester consumes it. Contention is resolved round-robin by default.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   mN_req_valid / mN_req_ready      request handshake (N = 0, 1)
//   mN_src1, mN_src2, mN_fn          operands and function code from requester N
//   mN_rsp_valid / mN_rsp_ready      response handshake (N = 0, 1)
//   mN_rsp_data                      captured result, shared by both requesters
//   alu_src1, alu_src2, alu_fn       to the shared ALU, zero outside EXEC
//   alu_result                       combinational result from the ALU
//
// Macro ALU_ARBITER_FIXED_PRIO_EN: when defined, m0 always wins contention and
// the last-grant pointer is not built.

module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic [31:0] m0_src1,
    input  logic [31:0] m0_src2,
    input  logic [5:0]  m0_fn,
    output logic        m0_rsp_valid,
    input  logic        m0_rsp_ready,
    output logic [31:0] m0_rsp_data,
    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic [31:0] m1_src1,
    input  logic [31:0] m1_src2,
    input  logic [5:0]  m1_fn,
    output logic        m1_rsp_valid,
    input  logic        m1_rsp_ready,
    output logic [31:0] m1_rsp_data,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [5:0]  alu_fn,
    input  logic [31:0] alu_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] src1_q, src1_d;
    logic [31:0] src2_q, src2_d;
    logic [5:0]  fn_q, fn_d;
    logic        owner_q, owner_d;
    logic [31:0] result_q, result_d;
    logic        grant_id;
    logic        accept;
    logic        owner_rsp_ready;

`ifndef ALU_ARBITER_FIXED_PRIO_EN
    logic        last_q, last_d;
`endif

    // grant_id: 0 selects m0, 1 selects m1. A lone requester always wins.
    always_comb begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
        grant_id = ~m0_req_valid;
`else
        if (m0_req_valid && m1_req_valid) begin
            grant_id = ~last_q;
        end else begin
            grant_id = ~m0_req_valid;
        end
`endif
    end

    // Ready is held low while rst is high so no request is handshaken on an
    // edge that is about to discard it.
    assign accept          = (state_q == IDLE) && (m0_req_valid || m1_req_valid) && !rst;
    assign m0_req_ready    = accept && !grant_id;
    assign m1_req_ready    = accept && grant_id;
    assign owner_rsp_ready = owner_q ? m1_rsp_ready : m0_rsp_ready;

    always_comb begin
        state_d  = state_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        fn_d     = fn_q;
        owner_d  = owner_q;
        result_d = result_q;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
        last_d   = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    src1_d  = grant_id ? m1_src1 : m0_src1;
                    src2_d  = grant_id ? m1_src2 : m0_src2;
                    fn_d    = grant_id ? m1_fn   : m0_fn;
                    owner_d = grant_id;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
                    last_d  = grant_id;
`endif
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_result;
                state_d  = RESP;
            end
            RESP: begin
                // Non-owner ready is deliberately not looked at.
                if (owner_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            src1_q   <= '0;
            src2_q   <= '0;
            fn_q     <= '0;
            owner_q  <= 1'b0;
            result_q <= '0;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            fn_q     <= fn_d;
            owner_q  <= owner_d;
            result_q <= result_d;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
            last_q   <= last_d;
`endif
        end
    end

    assign alu_src1     = (state_q == EXEC) ? src1_q : '0;
    assign alu_src2     = (state_q == EXEC) ? src2_q : '0;
    assign alu_fn       = (state_q == EXEC) ? fn_q   : '0;
    assign m0_rsp_valid = (state_q == RESP) && !owner_q;
    assign m1_rsp_valid = (state_q == RESP) && owner_q;
    assign m0_rsp_data  = result_q;
    assign m1_rsp_data  = result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_req_valid, m0_req_ready, m0_rsp_valid, m0_rsp_ready;
    logic [31:0] m0_src1, m0_src2, m0_rsp_data;
    logic [5:0]  m0_fn;
    logic        m1_req_valid, m1_req_ready, m1_rsp_valid, m1_rsp_ready;
    logic [31:0] m1_src1, m1_src2, m1_rsp_data;
    logic [5:0]  m1_fn;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic [5:0]  alu_fn;
    logic [137:0] all_outs;

    assign alu_result = alu_src1 + alu_src2;
    assign all_outs = {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid,
                       m0_rsp_data, m1_rsp_data, alu_src1, alu_src2, alu_fn};

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
        .m0_src1(m0_src1), .m0_src2(m0_src2), .m0_fn(m0_fn),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rsp_data(m0_rsp_data),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
        .m1_src1(m1_src1), .m1_src2(m1_src2), .m1_fn(m1_fn),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rsp_data(m1_rsp_data),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_fn(alu_fn),
        .alu_result(alu_result)
    );

    int checks = 0;
    int failures = 0;
    int model_last;

    logic [31:0] p_src1 [0:1];
    logic [31:0] p_src2 [0:1];
    logic [5:0]  p_fn   [0:1];

    int          e_id[$], e_rid[$], e_acc[$], e_rsp[$];
    logic [31:0] e_exp[$], e_data[$];
    bit          e_timeout, e_dual;
    int          m_id[$];

    // Reference: order of grants from the pending counts alone.
    task automatic model_grants(input int n0, input int n1, input int n_stop);
        int c[2];
        int w;
        c[0] = n0;
        c[1] = n1;
        m_id.delete();
        for (int i = 0; i < n_stop; i++) begin
            if (c[0] > 0 && c[1] > 0) begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
                w = 0;
`else
                w = 1 - model_last;
`endif
            end else begin
                w = (c[0] > 0) ? 0 : 1;
            end
            m_id.push_back(w);
            c[w] = c[w] - 1;
            model_last = w;
        end
    endtask

    task automatic new_ops(input int n);
        p_src1[n] = $urandom;
        p_src2[n] = $urandom;
        p_fn[n]   = 6'($urandom_range(0, 63));
    endtask

    // Requesters keep valid high while they have work; records observations only.
    task automatic engine(input int n0, input int n1, input int n_stop, input bit rnd_ready);
        int rem[2];
        int done;
        int cyc;
        rem[0] = n0;
        rem[1] = n1;
        done = 0;
        cyc = 0;
        e_timeout = 0;
        e_dual = 0;
        e_id.delete(); e_rid.delete(); e_acc.delete(); e_rsp.delete();
        e_exp.delete(); e_data.delete();
        while (done < n_stop) begin
            @(negedge clk);
            m0_req_valid = (rem[0] > 0);
            m1_req_valid = (rem[1] > 0);
            m0_src1 = p_src1[0]; m0_src2 = p_src2[0]; m0_fn = p_fn[0];
            m1_src1 = p_src1[1]; m1_src2 = p_src2[1]; m1_fn = p_fn[1];
            m0_rsp_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            m1_rsp_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (m0_req_ready && m1_req_ready) e_dual = 1;
            if (m0_req_valid && m0_req_ready) begin
                e_id.push_back(0); e_exp.push_back(p_src1[0] + p_src2[0]); e_acc.push_back(cyc);
                rem[0] = rem[0] - 1;
                new_ops(0);
            end else if (m1_req_valid && m1_req_ready) begin
                e_id.push_back(1); e_exp.push_back(p_src1[1] + p_src2[1]); e_acc.push_back(cyc);
                rem[1] = rem[1] - 1;
                new_ops(1);
            end
            if (m0_rsp_valid && m0_rsp_ready) begin
                e_rid.push_back(0); e_data.push_back(m0_rsp_data); e_rsp.push_back(cyc); done++;
            end
            if (m1_rsp_valid && m1_rsp_ready) begin
                e_rid.push_back(1); e_data.push_back(m1_rsp_data); e_rsp.push_back(cyc); done++;
            end
            cyc++;
            if (cyc > 500) begin
                e_timeout = 1;
                break;
            end
        end
        @(negedge clk);
        m0_req_valid = 0; m1_req_valid = 0; m0_rsp_ready = 0; m1_rsp_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (all_outs !== '0) begin failures++; $display("FAIL reset_outs: got %h expected 0", all_outs); end
        model_last = 1;
    endtask

    task automatic test_m0_only();
        @(negedge clk);
        m0_req_valid = 1; m0_src1 = 3; m0_src2 = 4; m0_fn = 6'h10;
        #1;
        checks++; if ({m0_req_ready, m1_req_ready} !== 2'b10) begin failures++; $display("FAIL m0only_ready: got %b expected 10", {m0_req_ready, m1_req_ready}); end
        model_last = 0;
        @(negedge clk);
        m0_req_valid = 0; m0_src1 = 0; m0_src2 = 0; m0_fn = 0;
        #1;
        checks++; if ({alu_src1, alu_src2, alu_fn} !== {32'd3, 32'd4, 6'h10}) begin failures++; $display("FAIL m0only_alu: got %0d %0d %h expected 3 4 10", alu_src1, alu_src2, alu_fn); end
        checks++; if ({m0_req_ready, m0_rsp_valid} !== 2'b00) begin failures++; $display("FAIL m0only_exec_ctl: got %b expected 00", {m0_req_ready, m0_rsp_valid}); end
        @(negedge clk);
        m0_rsp_ready = 1;
        #1;
        checks++; if ({m0_rsp_valid, m1_rsp_valid} !== 2'b10) begin failures++; $display("FAIL m0only_rspv: got %b expected 10", {m0_rsp_valid, m1_rsp_valid}); end
        checks++; if (m0_rsp_data !== 32'd7 || m1_rsp_data !== 32'd7) begin failures++; $display("FAIL m0only_data: got %0d %0d expected 7 7", m0_rsp_data, m1_rsp_data); end
        checks++; if (alu_src1 !== 32'd0) begin failures++; $display("FAIL m0only_alu_idle: got %0d expected 0", alu_src1); end
        @(negedge clk);
        m0_rsp_ready = 0;
        #1;
        checks++; if (m0_rsp_valid !== 1'b0) begin failures++; $display("FAIL m0only_done: got %b expected 0", m0_rsp_valid); end
    endtask

    task automatic test_contention_from_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_last = 1;
        p_src1[0] = 1;  p_src2[0] = 1;  p_fn[0] = 6'h20;
        p_src1[1] = 10; p_src2[1] = 20; p_fn[1] = 6'h21;
        engine(1, 1, 2, 0);
        model_grants(1, 1, 2);
        checks++; if (e_timeout || e_dual || e_rid.size() != 2 || e_id.size() != 2) begin failures++; $display("FAIL cont_run: timeout %0d dual %0d rsp %0d expected 0 0 2", e_timeout, e_dual, e_rid.size()); end
        else begin
            checks++; if ({e_id[0], e_id[1]} !== {32'd0, 32'd1}) begin failures++; $display("FAIL cont_order: got %0d %0d expected 0 1", e_id[0], e_id[1]); end
            checks++; if (e_data[0] !== 32'd2 || e_data[1] !== 32'd30) begin failures++; $display("FAIL cont_data: got %0d %0d expected 2 30", e_data[0], e_data[1]); end
            checks++; if (e_rsp[0] - e_acc[0] != 2) begin failures++; $display("FAIL cont_latency: got %0d expected 2", e_rsp[0] - e_acc[0]); end
            checks++; if (e_acc[1] != e_rsp[0] + 1) begin failures++; $display("FAIL cont_next_accept: got %0d expected %0d", e_acc[1], e_rsp[0] + 1); end
            checks++; if (e_rid[1] !== m_id[1]) begin failures++; $display("FAIL cont_owner: got %0d expected %0d", e_rid[1], m_id[1]); end
        end
    endtask

    task automatic test_alternate();
        new_ops(0); new_ops(1);
        model_grants(6, 6, 6);
        engine(6, 6, 6, 0);
        checks++; if (e_timeout || e_dual || e_rid.size() != 6 || e_id.size() != 6) begin failures++; $display("FAIL alt_run: timeout %0d dual %0d rsp %0d expected 0 0 6", e_timeout, e_dual, e_rid.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (e_id[i] != m_id[i] || e_rid[i] != m_id[i]) begin failures++; $display("FAIL alt_grant[%0d]: got %0d/%0d expected %0d", i, e_id[i], e_rid[i], m_id[i]); end
                checks++; if (e_data[i] !== e_exp[i]) begin failures++; $display("FAIL alt_data[%0d]: got %h expected %h", i, e_data[i], e_exp[i]); end
                checks++; if (e_rsp[i] - e_acc[i] != 2) begin failures++; $display("FAIL alt_latency[%0d]: got %0d expected 2", i, e_rsp[i] - e_acc[i]); end
                if (i > 0) begin
                    checks++; if (e_acc[i] != e_rsp[i-1] + 1) begin failures++; $display("FAIL alt_gap[%0d]: got %0d expected %0d", i, e_acc[i], e_rsp[i-1] + 1); end
                end
            end
        end
    endtask

    task automatic test_rsp_hold();
        logic [31:0] a0, b0, a1, b1, exp0, exp1;
        logic        stable_bad;
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        exp0 = a0 + b0;
        exp1 = a1 + b1;
        @(negedge clk);
        m0_req_valid = 1; m0_src1 = a0; m0_src2 = b0; m0_fn = 6'h3;
        #1;
        checks++; if (m0_req_ready !== 1'b1) begin failures++; $display("FAIL hold_accept0: got %b expected 1", m0_req_ready); end
        model_last = 0;
        @(negedge clk);
        m0_req_valid = 0;
        m1_req_valid = 1; m1_src1 = a1; m1_src2 = b1; m1_fn = 6'h3f;
        m1_rsp_ready = 1; m0_rsp_ready = 0;
        #1;
        checks++; if (m1_req_ready !== 1'b0) begin failures++; $display("FAIL hold_exec_ready1: got %b expected 0", m1_req_ready); end
        stable_bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            if ({m0_rsp_valid, m1_rsp_valid, m1_req_ready} !== 3'b100 || m0_rsp_data !== exp0) stable_bad = 1;
        end
        checks++; if (stable_bad !== 1'b0) begin failures++; $display("FAIL hold_stable: got %b expected 0", stable_bad); end
        @(negedge clk);
        m0_rsp_ready = 1;
        #1;
        checks++; if ({m0_rsp_valid, m1_req_ready} !== 2'b10 || m0_rsp_data !== exp0) begin failures++; $display("FAIL hold_handshake: got %b %h expected 10 %h", {m0_rsp_valid, m1_req_ready}, m0_rsp_data, exp0); end
        @(negedge clk);
        m0_rsp_ready = 0;
        #1;
        checks++; if ({m0_rsp_valid, m1_req_ready} !== 2'b01) begin failures++; $display("FAIL hold_accept1: got %b expected 01", {m0_rsp_valid, m1_req_ready}); end
        model_last = 1;
        @(negedge clk);
        m1_req_valid = 0;
        #1;
        checks++; if ({alu_src1, alu_src2, alu_fn} !== {a1, b1, 6'h3f}) begin failures++; $display("FAIL hold_alu1: got %h %h %h expected %h %h 3f", alu_src1, alu_src2, alu_fn, a1, b1); end
        @(negedge clk);
        #1;
        checks++; if ({m0_rsp_valid, m1_rsp_valid} !== 2'b01 || m1_rsp_data !== exp1) begin failures++; $display("FAIL hold_rsp1: got %b %h expected 01 %h", {m0_rsp_valid, m1_rsp_valid}, m1_rsp_data, exp1); end
        @(negedge clk);
        m1_rsp_ready = 0;
        #1;
        checks++; if (m1_rsp_valid !== 1'b0) begin failures++; $display("FAIL hold_done1: got %b expected 0", m1_rsp_valid); end
    endtask

    task automatic test_reset_exec();
        logic [31:0] a;
        logic        seen;
        a = $urandom | 32'h1;
        @(negedge clk);
        m1_req_valid = 1; m1_src1 = a; m1_src2 = 32'd9; m1_fn = 6'h11;
        #1;
        checks++; if (m1_req_ready !== 1'b1) begin failures++; $display("FAIL rstx_accept: got %b expected 1", m1_req_ready); end
        @(negedge clk);
        m1_req_valid = 0; rst = 1'b1; m0_rsp_ready = 1; m1_rsp_ready = 1;
        #1;
        checks++; if (alu_src1 !== a) begin failures++; $display("FAIL rstx_in_exec: got %h expected %h", alu_src1, a); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (all_outs !== '0) begin failures++; $display("FAIL rstx_outs: got %h expected 0", all_outs); end
        model_last = 1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (m0_rsp_valid || m1_rsp_valid || alu_src1 != 0) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstx_no_rsp: got %b expected 0", seen); end
        @(negedge clk);
        m0_rsp_ready = 0; m1_rsp_ready = 0;
    endtask

    task automatic test_fn_zero();
        p_src1[1] = 5; p_src2[1] = 6; p_fn[1] = 6'h00;
        model_grants(0, 1, 1);
        engine(0, 1, 1, 0);
        checks++; if (e_timeout || e_rid.size() != 1) begin failures++; $display("FAIL fn0_run: timeout %0d rsp %0d expected 0 1", e_timeout, e_rid.size()); end
        else begin
            checks++; if (e_rid[0] != m_id[0]) begin failures++; $display("FAIL fn0_owner: got %0d expected %0d", e_rid[0], m_id[0]); end
            checks++; if (e_data[0] !== e_exp[0]) begin failures++; $display("FAIL fn0_data: got %0d expected %0d", e_data[0], e_exp[0]); end
        end
    endtask

    task automatic test_random();
        int n0, n1, n;
        for (int r = 0; r < 4; r++) begin
            n0 = $urandom_range(0, 4);
            n1 = $urandom_range(1, 4);
            n = n0 + n1;
            new_ops(0); new_ops(1);
            model_grants(n0, n1, n);
            engine(n0, n1, n, 1);
            checks++; if (e_timeout || e_dual || e_rid.size() != n || e_id.size() != n) begin failures++; $display("FAIL rnd_run[%0d]: timeout %0d dual %0d rsp %0d expected 0 0 %0d", r, e_timeout, e_dual, e_rid.size(), n); end
            else begin
                for (int i = 0; i < n; i++) begin
                    checks++; if (e_id[i] != m_id[i] || e_rid[i] != m_id[i]) begin failures++; $display("FAIL rnd_grant[%0d.%0d]: got %0d/%0d expected %0d", r, i, e_id[i], e_rid[i], m_id[i]); end
                    checks++; if (e_data[i] !== e_exp[i]) begin failures++; $display("FAIL rnd_data[%0d.%0d]: got %h expected %h", r, i, e_data[i], e_exp[i]); end
                    checks++; if (e_rsp[i] - e_acc[i] < 2) begin failures++; $display("FAIL rnd_latency[%0d.%0d]: got %0d expected >=2", r, i, e_rsp[i] - e_acc[i]); end
                    if (i > 0) begin
                        checks++; if (e_acc[i] != e_rsp[i-1] + 1) begin failures++; $display("FAIL rnd_gap[%0d.%0d]: got %0d expected %0d", r, i, e_acc[i], e_rsp[i-1] + 1); end
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        m0_req_valid = 0; m0_src1 = 0; m0_src2 = 0; m0_fn = 0; m0_rsp_ready = 0;
        m1_req_valid = 0; m1_src1 = 0; m1_src2 = 0; m1_fn = 0; m1_rsp_ready = 0;
        model_last = 1;
        test_reset();
        test_m0_only();
        test_contention_from_reset();
        test_alternate();
        test_rsp_hold();
        test_reset_exec();
        test_fn_zero();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
